// File: rtl/cmd_rx_pkg.sv
// Shared constants and types for the RS422 command receive controller.
//   HDR0/HDR1   : frame sync bytes
//   state_t     : one-hot receive FSM encoding
//   ERR_*       : frame rejection cause codes reported on err_code
//   len_valid   : payload length acceptance test
package cmd_rx_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ST_W   = 6;
    localparam int unsigned ERR_W  = 2;

    localparam logic [BYTE_W-1:0] HDR0 = 8'hEB;
    localparam logic [BYTE_W-1:0] HDR1 = 8'h90;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 6'b000001,
        ST_HDR2  = 6'b000010,
        ST_LEN   = 6'b000100,
        ST_DATA  = 6'b001000,
        ST_CKSUM = 6'b010000,
        ST_PUSH  = 6'b100000
    } state_t;

    localparam logic [ERR_W-1:0] ERR_HDR   = 2'd0;
    localparam logic [ERR_W-1:0] ERR_LEN   = 2'd1;
    localparam logic [ERR_W-1:0] ERR_CKSUM = 2'd2;
    localparam logic [ERR_W-1:0] ERR_TMO   = 2'd3;

    // Non-zero and no larger than the payload buffer.
    function automatic logic len_valid(input logic [BYTE_W-1:0] len,
                                       input logic [BYTE_W-1:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/cmd_rx_gap_timer.sv
// Inter-byte gap timer for the receive FSM.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count (byte strobe or FSM idle)
//   run      : count enable (FSM inside a frame, before PUSH)
//   timeout  : high once the count has been running GAP_CYC cycles since clr
module cmd_rx_gap_timer
    import cmd_rx_pkg::*;
#(
    parameter int unsigned GAP_CYC = 50000,
    parameter int unsigned WIDTH   = $clog2(GAP_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic timeout
);

    // Decoding one short of GAP_CYC lets the FSM register frame_err on the
    // GAP_CYC-th edge after the last byte.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(GAP_CYC - 1);

    logic [WIDTH-1:0] cnt;

    // Saturating counter; the FSM leaves the counting states on timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && (cnt != LAST)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign timeout = run && (cnt == LAST);

endmodule

// File: rtl/cmd_rx_ctrl.sv
// Receive-side command controller for the RS422 command link.
// Parses [EB 90 LEN PAYLOAD CKSUM] frames from the UART RX core, buffers the
// payload and forwards it to the command FIFO only once the checksum matches.
//   clk, rst        : clock, synchronous active-high reset
//   ENABLE          : receive enable, honoured only when idle
//   rx_done/rx_data : received byte strobe and data
//   full            : downstream FIFO full
//   wen/wdata       : FIFO write strobe and data
//   frame_ok        : pulse, cycle after the last payload byte is written
//   frame_err       : pulse on frame rejection, cause held on err_code
//   overrun         : pulse when a byte arrives while draining the buffer
//   busy            : high whenever a frame is in progress
module cmd_rx_ctrl
    import cmd_rx_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned GAP_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ENABLE,
    input  logic              rx_done,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              full,
    output logic              wen,
    output logic [BYTE_W-1:0] wdata,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [ERR_W-1:0]  err_code,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned       IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [BYTE_W-1:0] len_last;
    logic [BYTE_W-1:0] sum;
    logic              ok_pend;
    logic [BYTE_W-1:0] pay_q [MAX_LEN];

    logic              gap_clr_c;
    logic              gap_run_c;
    logic              gap_tmo_c;
    logic              buf_we_c;
    logic              idx_last_c;
    logic              rej_c;
    logic [ERR_W-1:0]  rej_code_c;

    assign gap_clr_c  = rx_done || (state == ST_IDLE);
    assign gap_run_c  = state inside {ST_HDR2, ST_LEN, ST_DATA, ST_CKSUM};
    assign buf_we_c   = (state == ST_DATA) && rx_done;
    assign idx_last_c = (BYTE_W'(idx) == len_last);

    cmd_rx_gap_timer #(
        .GAP_CYC (GAP_CYC),
        .WIDTH   ($clog2(GAP_CYC + 1))
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (gap_clr_c),
        .run     (gap_run_c),
        .timeout (gap_tmo_c)
    );

    // Frame rejection decode; a byte arriving on the timeout cycle wins.
    always_comb begin
        rej_c      = 1'b0;
        rej_code_c = ERR_HDR;
        if (rx_done) begin
            case (state)
                ST_HDR2: begin
                    if ((rx_data != HDR1) && (rx_data != HDR0)) begin
                        rej_c      = 1'b1;
                        rej_code_c = ERR_HDR;
                    end
                end
                ST_LEN: begin
                    if (!len_valid(rx_data, MAX_LEN_B)) begin
                        rej_c      = 1'b1;
                        rej_code_c = ERR_LEN;
                    end
                end
                ST_CKSUM: begin
                    if (rx_data != sum) begin
                        rej_c      = 1'b1;
                        rej_code_c = ERR_CKSUM;
                    end
                end
                default: ;
            endcase
        end else if (gap_tmo_c) begin
            rej_c      = 1'b1;
            rej_code_c = ERR_TMO;
        end
    end

    // Payload buffer: written while collecting, read while draining.
    always_ff @(posedge clk) begin
        if (buf_we_c) begin
            pay_q[idx] <= rx_data;
        end
    end

    // Receive FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            len_last  <= '0;
            sum       <= '0;
            ok_pend   <= 1'b0;
            wen       <= 1'b0;
            wdata     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_HDR;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wen       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            frame_ok  <= ok_pend;
            ok_pend   <= 1'b0;
            if (rej_c) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
                err_code  <= rej_code_c;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_done && ENABLE && (rx_data == HDR0)) begin
                            state <= ST_HDR2;
                            busy  <= 1'b1;
                        end
                    end
                    // A repeated HDR0 keeps us here; bad bytes are rejected above.
                    ST_HDR2: begin
                        if (rx_done && (rx_data == HDR1)) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_done) begin
                            len_last <= rx_data - 8'd1;
                            sum      <= '0;
                            idx      <= '0;
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (rx_done) begin
                            sum <= sum + rx_data;
                            idx <= idx + IDX_W'(1);
                            if (idx_last_c) begin
                                state <= ST_CKSUM;
                            end
                        end
                    end
                    ST_CKSUM: begin
                        if (rx_done) begin
                            idx   <= '0;
                            state <= ST_PUSH;
                        end
                    end
                    // Drain to FIFO; stalls on full, bytes arriving now are lost.
                    ST_PUSH: begin
                        overrun <= rx_done;
                        if (!full) begin
                            wen   <= 1'b1;
                            wdata <= pay_q[idx];
                            idx   <= idx + IDX_W'(1);
                            if (idx_last_c) begin
                                state   <= ST_IDLE;
                                busy    <= 1'b0;
                                ok_pend <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_rx_ctrl.sv
// Self-checking bench for cmd_rx_ctrl: frames are built at byte-stream level,
// expected FIFO bytes and frame outcomes are queued when stimulus is issued and
// a negedge monitor pops and compares whatever the DUT presents.
module tb_cmd_rx_ctrl;

    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned GAP_CYC = 60;
    localparam logic [7:0]  SYNC0   = 8'hEB;
    localparam logic [7:0]  SYNC1   = 8'h90;
    localparam int          RES_OK  = -1;

    logic       clk = 1'b0;
    logic       rst;
    logic       ENABLE;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       full;
    logic       wen;
    logic [7:0] wdata;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wen_cnt  = 0;
    int ovr_seen = 0;
    int exp_ovr  = 0;
    int last_err_cyc = 0;
    bit prev_wen = 1'b0;

    logic [7:0] exp_bytes[$];
    int         exp_res[$];

    cmd_rx_ctrl #(
        .MAX_LEN (MAX_LEN),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ENABLE    (ENABLE),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .full      (full),
        .wen       (wen),
        .wdata     (wdata),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        logic [7:0] e;
        int         r;
        if (rst) begin
            prev_wen = 1'b0;
        end else begin
            if (frame_ok || frame_err) chk("ok_err_exclusive", int'(frame_ok & frame_err), 0);
            if (wen) begin
                wen_cnt++;
                if (exp_bytes.size() == 0) begin
                    chk("spurious_wen", int'(wen), 0);
                end else begin
                    e = exp_bytes.pop_front();
                    chk("wdata", int'(wdata), int'(e));
                end
            end
            if (frame_ok) begin
                chk("frame_ok_after_last_wen", int'(prev_wen), 1);
                if (exp_res.size() == 0) begin
                    chk("spurious_frame_ok", int'(frame_ok), 0);
                end else begin
                    r = exp_res.pop_front();
                    chk("frame_result", RES_OK, r);
                end
            end
            if (frame_err) begin
                last_err_cyc = cyc;
                if (exp_res.size() == 0) begin
                    chk("spurious_frame_err", int'(frame_err), 0);
                end else begin
                    r = exp_res.pop_front();
                    chk("frame_result", int'(err_code), r);
                end
            end
            if (overrun) ovr_seen++;
            prev_wen = wen;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    function automatic int rg();
        return int'($urandom_range(0, 8));
    endfunction

    task automatic wait_idle(input bit rand_full);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            if (rand_full) full = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            n++;
        end
        full = 1'b0;
        if (n >= 3000) chk("idle_wait_expired", int'(busy), 0);
    endtask

    // Complete frame with random payload; bad_ck corrupts the checksum byte.
    task automatic send_frame(input int len, input bit extra_eb, input bit drop_en,
                              input bit bad_ck);
        logic [7:0] s;
        logic [7:0] b;
        logic [7:0] pay[$];
        s = 8'h00;
        send_byte(SYNC0, rg());
        if (drop_en) ENABLE = 1'b0;
        if (extra_eb) send_byte(SYNC0, rg());
        send_byte(SYNC1, rg());
        send_byte(8'(len), rg());
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            pay.push_back(b);
            s = s + b;
            send_byte(b, rg());
        end
        if (bad_ck) begin
            exp_res.push_back(2);
            send_byte(s ^ 8'($urandom_range(1, 255)), 0);
        end else begin
            foreach (pay[i]) exp_bytes.push_back(pay[i]);
            exp_res.push_back(RES_OK);
            send_byte(s, 0);
        end
        ENABLE = 1'b1;
    endtask

    initial begin
        int t0;
        int wc0;
        int ov0;
        int kind;
        int len;
        int stage;
        logic [7:0] b;

        rst     = 1'b1;
        ENABLE  = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        full    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_wen", int'(wen), 0);
        chk("rst_frame_ok", int'(frame_ok), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_busy", int'(busy), 0);

        // Basic good frame
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        exp_bytes.push_back(8'h33);
        exp_res.push_back(RES_OK);
        send_byte(8'hEB, 1); send_byte(8'h90, 1); send_byte(8'h03, 1);
        send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
        send_byte(8'h66, 0);
        wait_idle(1'b0);
        repeat (3) @(negedge clk);

        // Checksum error
        exp_res.push_back(2);
        send_byte(8'hEB, 1); send_byte(8'h90, 1); send_byte(8'h02, 1);
        send_byte(8'hAA, 1); send_byte(8'hBB, 1); send_byte(8'h00, 0);
        chk("busy_after_cksum_err", int'(busy), 0);
        repeat (3) @(negedge clk);

        // Length bounds
        exp_res.push_back(1);
        send_byte(8'hEB, 1); send_byte(8'h90, 1); send_byte(8'h00, 0);
        chk("busy_after_len0", int'(busy), 0);
        exp_res.push_back(1);
        send_byte(8'hEB, 1); send_byte(8'h90, 1); send_byte(8'h21, 0);
        chk("busy_after_len33", int'(busy), 0);
        repeat (3) @(negedge clk);
        send_frame(int'(MAX_LEN), 1'b0, 1'b0, 1'b0);
        wait_idle(1'b0);

        // Gap timeout latency
        exp_res.push_back(3);
        send_byte(8'hEB, 1); send_byte(8'h90, 1); send_byte(8'h04, 1);
        send_byte(8'h01, 1); send_byte(8'h02, 0);
        t0 = cyc;
        repeat (GAP_CYC - 1) @(negedge clk);
        chk("busy_just_before_timeout", int'(busy), 1);
        repeat (6) @(negedge clk);
        chk("timeout_latency", last_err_cyc - t0, int'(GAP_CYC));
        chk("busy_after_timeout", int'(busy), 0);
        send_frame(4, 1'b0, 1'b0, 1'b0);
        wait_idle(1'b1);

        // Back-pressure with overrun byte during PUSH
        full = 1'b1;
        send_frame(4, 1'b0, 1'b0, 1'b0);
        wc0 = wen_cnt;
        ov0 = ovr_seen;
        repeat (2) @(negedge clk);
        exp_ovr++;
        send_byte(8'h5A, 0);
        repeat (15) @(negedge clk);
        chk("wen_while_full", wen_cnt - wc0, 0);
        chk("overrun_pulse", ovr_seen - ov0, 1);
        full = 1'b0;
        wait_idle(1'b0);
        repeat (3) @(negedge clk);
        chk("wen_after_full_drop", wen_cnt - wc0, 4);

        // Repeated header, single byte payload
        exp_bytes.push_back(8'h7F);
        exp_res.push_back(RES_OK);
        send_byte(8'hEB, 1); send_byte(8'hEB, 1); send_byte(8'h90, 1);
        send_byte(8'h01, 1); send_byte(8'h7F, 1); send_byte(8'h7F, 0);
        wait_idle(1'b0);
        repeat (3) @(negedge clk);

        // Reset during DATA
        wc0 = wen_cnt;
        send_byte(8'hEB, 1); send_byte(8'h90, 1); send_byte(8'h05, 1);
        send_byte(8'h01, 1); send_byte(8'h02, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("busy_after_rst_data", int'(busy), 0);
        chk("err_code_after_rst", int'(err_code), 0);
        repeat (10) @(negedge clk);
        chk("wen_after_rst_data", wen_cnt - wc0, 0);

        // Reset during a stalled PUSH
        full = 1'b1;
        send_byte(8'hEB, 1); send_byte(8'h90, 1); send_byte(8'h01, 1);
        send_byte(8'h44, 1); send_byte(8'h44, 2);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        full = 1'b0;
        repeat (10) @(negedge clk);
        chk("wen_after_rst_push", wen_cnt - wc0, 0);
        chk("busy_after_rst_push", int'(busy), 0);

        // ENABLE low in idle ignores a frame start
        ENABLE = 1'b0;
        send_byte(8'hEB, 1); send_byte(8'h90, 1); send_byte(8'h01, 1);
        send_byte(8'h55, 1); send_byte(8'h55, 1);
        ENABLE = 1'b1;
        chk("busy_enable_low", int'(busy), 0);

        // Randomized frame mix
        for (int f = 0; f < 60; f++) begin
            kind = int'($urandom_range(0, 6));
            case (kind)
                0, 1: begin
                    len = int'($urandom_range(1, MAX_LEN));
                    send_frame(len, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1'b0);
                end
                2: begin
                    b = 8'($urandom);
                    while (b == SYNC0 || b == SYNC1) b = 8'($urandom);
                    exp_res.push_back(0);
                    send_byte(SYNC0, rg());
                    send_byte(b, 0);
                end
                3: begin
                    b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
                    exp_res.push_back(1);
                    send_byte(SYNC0, rg());
                    send_byte(SYNC1, rg());
                    send_byte(b, 0);
                end
                4: begin
                    send_frame(int'($urandom_range(1, MAX_LEN)), 1'b0, 1'b0, 1'b1);
                end
                5: begin
                    len   = int'($urandom_range(2, MAX_LEN));
                    stage = int'($urandom_range(0, 3));
                    exp_res.push_back(3);
                    send_byte(SYNC0, rg());
                    if (stage >= 1) send_byte(SYNC1, rg());
                    if (stage >= 2) send_byte(8'(len), rg());
                    if (stage >= 3) begin
                        for (int i = 0; i < int'($urandom_range(1, len - 1)); i++) begin
                            send_byte(8'($urandom), rg());
                        end
                    end
                    repeat (GAP_CYC + 10) @(negedge clk);
                end
                default: begin
                    b = 8'($urandom);
                    if (b == SYNC0) b = 8'h00;
                    send_byte(b, rg());
                end
            endcase
            wait_idle(1'b1);
        end

        repeat (20) @(negedge clk);
        chk("bytes_outstanding", exp_bytes.size(), 0);
        chk("results_outstanding", exp_res.size(), 0);
        chk("overrun_total", ovr_seen, exp_ovr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
